sdram_p2_line_bridge: RTL and testbench



---
 rtl/sdram_p2_line_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_p2_line_bridge.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_p2_line_bridge.sv
// Host-side client for SDRAM controller port 2: 16-bit word reads/writes served
// from a single 4-word write-back line buffer, refilled/evicted as whole 64-bit lines.
module sdram_p2_line_bridge (
    input  logic        clk,
    input  logic        rst,
    input  logic [21:0] host_addr,
    input  logic [15:0] host_wdata,
    input  logic        host_rd,
    input  logic        host_wr,
    input  logic        host_flush,
    output logic [15:0] host_rdata,
    output logic        host_done,
    output logic        host_busy,
    output logic [12:0] p2_address,
    output logic [6:0]  p2_page,
    output logic [63:0] p2_to_mem,
    input  logic [63:0] p2_from_mem,
    output logic        p2_req,
    output logic        p2_wren,
    input  logic        p2_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH_REQ,
        S_FLUSH_WAIT,
        S_FILL_REQ,
        S_FILL_WAIT
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] line_q, line_d;
    logic [19:0] tag_q, tag_d;
    logic        valid_q, valid_d;
    logic        dirty_q, dirty_d;
    logic        pend_wr_q, pend_wr_d;
    logic        pend_flush_q, pend_flush_d;
    logic [21:0] pend_addr_q, pend_addr_d;
    logic [15:0] pend_wdata_q, pend_wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic [19:0] p2_line_q, p2_line_d;
    logic [63:0] p2_data_q, p2_data_d;
    logic        p2_wren_q, p2_wren_d;

    logic cmd_flush, cmd_wr, cmd_rd, hit, need_wb;

    function automatic logic [15:0] word_get(input logic [63:0] l, input logic [1:0] idx);
        return l[{idx, 4'b0000} +: 16];
    endfunction

    function automatic logic [63:0] word_put(input logic [63:0] l, input logic [1:0] idx,
                                             input logic [15:0] w);
        logic [63:0] r;
        r = l;
        r[{idx, 4'b0000} +: 16] = w;
        return r;
    endfunction

    // Flush beats write beats read; lower-priority commands in the same cycle are dropped.
    assign cmd_flush = host_flush;
    assign cmd_wr    = host_wr & ~host_flush;
    assign cmd_rd    = host_rd & ~host_wr & ~host_flush;
    assign hit       = valid_q && (host_addr[21:2] == tag_q);
    assign need_wb   = valid_q & dirty_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            valid_q      <= 1'b0;
            dirty_q      <= 1'b0;
            pend_wr_q    <= 1'b0;
            pend_flush_q <= 1'b0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
            p2_line_q    <= '0;
            p2_data_q    <= '0;
            p2_wren_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            pend_wr_q    <= pend_wr_d;
            pend_flush_q <= pend_flush_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            p2_line_q    <= p2_line_d;
            p2_data_q    <= p2_data_d;
            p2_wren_q    <= p2_wren_d;
        end
    end

    // Line contents and the latched miss command are meaningless while valid/state say so.
    always_ff @(posedge clk) begin
        line_q       <= line_d;
        tag_q        <= tag_d;
        pend_addr_q  <= pend_addr_d;
        pend_wdata_q <= pend_wdata_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_flush) begin
                    if (need_wb) state_d = S_FLUSH_REQ;
                end else if ((cmd_wr || cmd_rd) && !hit) begin
                    state_d = need_wb ? S_FLUSH_REQ : S_FILL_REQ;
                end
            end
            S_FLUSH_REQ:  state_d = S_FLUSH_WAIT;
            S_FLUSH_WAIT: if (p2_ready) state_d = pend_flush_q ? S_IDLE : S_FILL_REQ;
            S_FILL_REQ:   state_d = S_FILL_WAIT;
            S_FILL_WAIT:  if (p2_ready) state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        host_busy  = (state_q != S_IDLE);
        p2_req     = (state_q == S_FLUSH_REQ) || (state_q == S_FILL_REQ);
        host_done  = done_q;
        host_rdata = rdata_q;
        p2_wren    = p2_wren_q;
        p2_address = p2_line_q[12:0];
        p2_page    = p2_line_q[19:13];
        p2_to_mem  = p2_data_q;
    end

    // Port-2 address/data/wren only change on entry to a REQ state, so they stay
    // stable for a controller that latches the request late.
    always_comb begin
        line_d       = line_q;
        tag_d        = tag_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        pend_wr_d    = pend_wr_q;
        pend_flush_d = pend_flush_q;
        pend_addr_d  = pend_addr_q;
        pend_wdata_d = pend_wdata_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        p2_line_d    = p2_line_q;
        p2_data_d    = p2_data_q;
        p2_wren_d    = p2_wren_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_flush) begin
                    if (need_wb) begin
                        pend_flush_d = 1'b1;
                        p2_line_d    = tag_q;
                        p2_data_d    = line_q;
                        p2_wren_d    = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (cmd_wr || cmd_rd) begin
                    if (hit) begin
                        done_d = 1'b1;
                        if (cmd_wr) begin
                            line_d  = word_put(line_q, host_addr[1:0], host_wdata);
                            dirty_d = 1'b1;
                        end else begin
                            rdata_d = word_get(line_q, host_addr[1:0]);
                        end
                    end else begin
                        pend_flush_d = 1'b0;
                        pend_wr_d    = cmd_wr;
                        pend_addr_d  = host_addr;
                        pend_wdata_d = host_wdata;
                        p2_wren_d    = need_wb;
                        p2_line_d    = need_wb ? tag_q : host_addr[21:2];
                        if (need_wb) p2_data_d = line_q;
                    end
                end
            end
            S_FLUSH_WAIT: begin
                if (p2_ready) begin
                    dirty_d = 1'b0;
                    if (pend_flush_q) begin
                        done_d = 1'b1;
                    end else begin
                        p2_wren_d = 1'b0;
                        p2_line_d = pend_addr_q[21:2];
                    end
                end
            end
            S_FILL_WAIT: begin
                if (p2_ready) begin
                    tag_d   = pend_addr_q[21:2];
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    if (pend_wr_q) begin
                        line_d  = word_put(p2_from_mem, pend_addr_q[1:0], pend_wdata_q);
                        dirty_d = 1'b1;
                    end else begin
                        line_d  = p2_from_mem;
                        rdata_d = word_get(p2_from_mem, pend_addr_q[1:0]);
                        dirty_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_p2_line_bridge.sv
// Scoreboard bench for sdram_p2_line_bridge: a transaction-level cache/memory model
// predicts host completions and port-2 traffic; monitors compare as the DUT responds.
module tb_sdram_p2_line_bridge;

    logic        clk, rst;
    logic [21:0] host_addr;
    logic [15:0] host_wdata;
    logic        host_rd, host_wr, host_flush;
    logic [15:0] host_rdata;
    logic        host_done, host_busy;
    logic [12:0] p2_address;
    logic [6:0]  p2_page;
    logic [63:0] p2_to_mem, p2_from_mem;
    logic        p2_req, p2_wren, p2_ready;

    sdram_p2_line_bridge dut (
        .clk(clk), .rst(rst),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rd(host_rd), .host_wr(host_wr), .host_flush(host_flush),
        .host_rdata(host_rdata), .host_done(host_done), .host_busy(host_busy),
        .p2_address(p2_address), .p2_page(p2_page), .p2_to_mem(p2_to_mem),
        .p2_from_mem(p2_from_mem), .p2_req(p2_req), .p2_wren(p2_wren),
        .p2_ready(p2_ready)
    );

    typedef struct { bit is_rd; logic [15:0] rdata; bit slow; int due; } done_t;
    typedef struct { bit wren; logic [19:0] tag; logic [63:0] data; int due; } p2_t;

    done_t exp_done[$];
    p2_t   exp_p2[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, slow_issued = 0, slow_done = 0, last_ready_cyc = -100;
    bit long_mode = 0;

    logic [63:0] mem [int];
    bit          m_valid = 0, m_dirty = 0;
    logic [19:0] m_tag = '0;
    logic [63:0] m_line = '0;
    logic [19:0] tags [6] = '{20'h00000, 20'h00001, 20'h00002, 20'h00003, 20'h40000, 20'h40001};

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input logic [127:0] act,
                         input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [63:0] mem_rd(input logic [19:0] t);
        int k;
        k = int'(t);
        if (mem.exists(k)) return mem[k];
        return {t[15:0] ^ 16'hA5A5, t[15:0] + 16'd3, ~t[15:0], t[15:0] * 16'd7};
    endfunction

    // Reference behaviour of one accepted command at the transaction level.
    task automatic model_cmd(input bit rd, input bit wr, input bit fl,
                             input logic [21:0] a, input logic [15:0] wd);
        done_t d;
        p2_t p;
        logic [19:0] t;
        int w;
        if (!(rd || wr || fl)) return;
        t = a[21:2];
        w = int'(a[1:0]);
        d.is_rd = 0; d.rdata = '0; d.slow = 0; d.due = cyc + 1;
        p.due = cyc + 1;
        if (fl) begin
            if (m_valid && m_dirty) begin
                p.wren = 1; p.tag = m_tag; p.data = m_line;
                exp_p2.push_back(p);
                mem[int'(m_tag)] = m_line;
                m_dirty = 0;
                d.slow = 1;
                slow_issued++;
            end
        end else if (m_valid && t == m_tag) begin
            if (wr) begin
                m_line[16*w +: 16] = wd;
                m_dirty = 1;
            end else begin
                d.is_rd = 1;
                d.rdata = m_line[16*w +: 16];
            end
        end else begin
            if (m_valid && m_dirty) begin
                p.wren = 1; p.tag = m_tag; p.data = m_line;
                exp_p2.push_back(p);
                mem[int'(m_tag)] = m_line;
                p.due = -1;
            end
            p.wren = 0; p.tag = t; p.data = '0;
            exp_p2.push_back(p);
            m_line = mem_rd(t);
            if (wr) begin
                m_line[16*w +: 16] = wd;
                m_dirty = 1;
            end else begin
                d.is_rd = 1;
                d.rdata = m_line[16*w +: 16];
                m_dirty = 0;
            end
            m_tag = t;
            m_valid = 1;
            d.slow = 1;
            slow_issued++;
        end
        exp_done.push_back(d);
    endtask

    task automatic zero_inputs();
        host_rd = 0; host_wr = 0; host_flush = 0; host_addr = '0; host_wdata = '0;
    endtask

    // Waits for host_busy=0, driving ignored junk meanwhile, then presents the command.
    task automatic issue(input bit rd, input bit wr, input bit fl,
                         input logic [21:0] a, input logic [15:0] wd);
        bit sent;
        sent = 0;
        for (int g = 0; g < 300; g++) begin
            @(negedge clk);
            #1;
            if (!host_busy) begin
                host_rd = rd; host_wr = wr; host_flush = fl; host_addr = a; host_wdata = wd;
                model_cmd(rd, wr, fl, a, wd);
                sent = 1;
                break;
            end
            host_rd = 1'($urandom); host_wr = 1'($urandom); host_flush = 1'($urandom);
            host_addr = 22'($urandom); host_wdata = 16'($urandom);
        end
        if (!sent) check(0, "busy_timeout", host_busy, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            zero_inputs();
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            zero_inputs();
            if (exp_done.size() == 0 && exp_p2.size() == 0 && !host_busy) begin
                ok = 1;
                break;
            end
        end
        check(ok, "drain_timeout", exp_done.size() + exp_p2.size(), 0);
    endtask

    task automatic check_reset_values();
        check(host_rdata == 16'h0, "rst_host_rdata", host_rdata, 0);
        check(host_done == 1'b0, "rst_host_done", host_done, 0);
        check(host_busy == 1'b0, "rst_host_busy", host_busy, 0);
        check(p2_req == 1'b0, "rst_p2_req", p2_req, 0);
        check(p2_wren == 1'b0, "rst_p2_wren", p2_wren, 0);
        check(p2_address == 13'h0, "rst_p2_address", p2_address, 0);
        check(p2_page == 7'h0, "rst_p2_page", p2_page, 0);
        check(p2_to_mem == 64'h0, "rst_p2_to_mem", p2_to_mem, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1;
        zero_inputs();
        exp_done.delete();
        exp_p2.delete();
        slow_issued = slow_done;
        m_valid = 0;
        m_dirty = 0;
        @(negedge clk);
        check_reset_values();
        #1 rst = 0;
    endtask

    // Host-side monitor: completions, read data hold and busy.
    initial begin : host_mon
        done_t e;
        int exp_c;
        logic [15:0] hold;
        hold = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = '0;
                continue;
            end
            if (host_done) begin
                if (exp_done.size() == 0) begin
                    check(0, "done_unexpected", host_done, 0);
                end else begin
                    e = exp_done.pop_front();
                    exp_c = e.slow ? last_ready_cyc + 1 : e.due;
                    check(cyc == exp_c, "done_cycle", cyc, exp_c);
                    if (e.slow) slow_done++;
                    if (e.is_rd) hold = e.rdata;
                end
            end
            check(host_rdata == hold, "host_rdata", host_rdata, hold);
            check(host_busy == (slow_issued != slow_done), "host_busy", host_busy,
                  slow_issued != slow_done);
        end
    end

    // Port-2 controller model: checks each request, holds it for a while, then completes it.
    initial begin : p2_ctrl
        bit c_wren, aborted;
        logic [19:0] c_tag;
        logic [63:0] c_data;
        p2_t e;
        int d, exp_c;
        p2_ready = 0;
        p2_from_mem = '0;
        forever begin
            @(negedge clk);
            p2_ready = 0;
            if (rst) continue;
            if (p2_req) begin
                c_wren = p2_wren;
                c_tag  = {p2_page, p2_address};
                c_data = p2_to_mem;
                if (exp_p2.size() == 0) begin
                    check(0, "p2_req_unexpected", {c_wren, c_tag}, 0);
                end else begin
                    e = exp_p2.pop_front();
                    check(c_wren == e.wren, "p2_wren", c_wren, e.wren);
                    check(c_tag == e.tag, "p2_line_addr", c_tag, e.tag);
                    if (e.wren) check(c_data == e.data, "p2_to_mem", c_data, e.data);
                    exp_c = (e.due >= 0) ? e.due : last_ready_cyc + 1;
                    check(cyc == exp_c, "p2_req_cycle", cyc, exp_c);
                end
                d = long_mode ? 40 : $urandom_range(0, 4);
                aborted = 0;
                for (int k = 0; k <= d; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        aborted = 1;
                        break;
                    end
                    check({p2_req, p2_wren, p2_page, p2_address, p2_to_mem} ==
                          {1'b0, c_wren, c_tag, c_data}, "p2_hold",
                          {p2_req, p2_wren, p2_page, p2_address, p2_to_mem},
                          {1'b0, c_wren, c_tag, c_data});
                end
                if (!aborted) begin
                    p2_ready = 1;
                    p2_from_mem = c_wren ? {$urandom, $urandom} : mem_rd(c_tag);
                    last_ready_cyc = cyc;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                p2_ready = 1;
                p2_from_mem = {$urandom, $urandom};
            end
        end
    end

    initial begin : stimulus
        bit seen;
        rst = 1;
        zero_inputs();
        mem[1] = 64'h4444_3333_2222_1111;
        repeat (3) @(negedge clk);
        check_reset_values();
        #1 rst = 0;

        issue(1, 0, 0, 22'h000005, 16'h0);
        issue(0, 1, 0, 22'h000006, 16'hBEEF);
        issue(1, 0, 0, 22'h000006, 16'h0);
        issue(1, 0, 0, 22'h100000, 16'h0);
        issue(0, 0, 1, 22'h0, 16'h0);
        issue(0, 1, 0, 22'h100001, 16'h1234);
        issue(0, 0, 1, 22'h0, 16'h0);
        long_mode = 1;
        issue(1, 0, 0, 22'h000008, 16'h0);
        idle(2);
        long_mode = 0;
        issue(1, 1, 0, 22'h000009, 16'h7777);
        issue(1, 0, 0, 22'h000009, 16'h0);
        drain();

        for (int i = 0; i < 400; i++) begin
            int r;
            bit rd, wr, fl;
            logic [21:0] a;
            if ($urandom_range(0, 3) == 0) idle(1);
            r = $urandom_range(0, 9);
            rd = (r >= 1 && r <= 4);
            wr = (r >= 5 && r <= 8);
            fl = (r == 0);
            if (r == 9) {rd, wr, fl} = 3'($urandom);
            a = {tags[$urandom_range(0, 5)], 2'($urandom)};
            issue(rd, wr, fl, a, 16'($urandom));
        end
        drain();

        issue(1, 0, 0, 22'h00000C, 16'h0);
        issue(0, 1, 0, 22'h00000D, 16'h5A5A);
        drain();
        do_reset();
        issue(0, 0, 1, 22'h0, 16'h0);
        issue(1, 0, 0, 22'h00000D, 16'h0);
        drain();
        issue(1, 0, 0, 22'h000010, 16'h0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            zero_inputs();
            if (p2_req) begin
                seen = 1;
                break;
            end
        end
        check(seen, "p2_req_before_reset", seen, 1);
        do_reset();
        issue(1, 0, 0, 22'h000011, 16'h0);
        issue(0, 1, 0, 22'h000012, 16'hC0DE);
        issue(1, 0, 0, 22'h000012, 16'h0);
        drain();

        check(exp_done.size() == 0, "leftover_done", exp_done.size(), 0);
        check(exp_p2.size() == 0, "leftover_p2", exp_p2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
